// File: rtl/wire_alu.sv
// wire_alu: okClk-domain host arithmetic engine (ADD/SUB/ACC/shift-add MUL) with per-channel accumulators.
// Optional build macro WIRE_ALU_SAT_EN: clamp results on overflow/borrow instead of wrapping.
module wire_alu #(
   parameter int  WIDTH    = 32,
   parameter int  CHANNELS = 4,
   localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      okClk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [1:0]                op_sel,
   input  logic [CW-1:0]             chan_sel,
   input  logic                      acc_clr,
   input  logic [WIDTH-1:0]          op_a,
   input  logic [WIDTH-1:0]          op_b,
   output logic [WIDTH-1:0]          result,
   output logic [CHANNELS*WIDTH-1:0] acc_out,
   output logic                      busy,
   output logic                      done,
   output logic                      ovf,
   output logic                      err
);

   localparam int CNTW = $clog2(WIDTH);

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_ACC = 2'd2;
   localparam logic [1:0] OP_MUL = 2'd3;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_MUL  = 2'd2;

   logic [1:0]       state_reg;
   logic [CNTW-1:0]  cnt_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [1:0]       op_reg;
   logic [CW-1:0]    ch_reg;
   logic [WIDTH-1:0] result_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             ovf_reg;
   logic             err_reg;
   // Shift-add product: hi_reg collects partial sums, lo_reg holds the remaining multiplier bits.
   logic [WIDTH-1:0] hi_reg;
   logic [WIDTH-1:0] lo_reg;

   logic [CHANNELS-1:0] ch_hit;
   logic [CHANNELS-1:0] clr_hit;
   logic [WIDTH-1:0]    acc_word [CHANNELS];
   logic [WIDTH-1:0]    acc_cur;
   logic                ch_legal;
   logic                acc_wr;

   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   sub_full;
   logic [WIDTH:0]   acc_full;
   logic [WIDTH-1:0] mul_addend;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_next;
   logic [WIDTH-1:0] mul_lo_next;
   logic             mul_ovf;
   logic             mul_last;
   logic [WIDTH-1:0] add_res;
   logic [WIDTH-1:0] sub_res;
   logic [WIDTH-1:0] acc_res;
   logic [WIDTH-1:0] mul_res;
   logic [WIDTH-1:0] exec_res;
   logic             exec_ovf;

   assign acc_wr = (state_reg == S_EXEC) && (op_reg == OP_ACC);

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [WIDTH-1:0] acc_reg;

         assign ch_hit[gi]  = (ch_reg == CW'(gi));
         assign clr_hit[gi] = acc_clr && (chan_sel == CW'(gi));

         // A clear on the same edge as an ACC write to this channel takes priority.
         always_ff @(posedge okClk or posedge reset) begin
            if (reset) begin
               acc_reg <= '0;
            end else if (clr_hit[gi]) begin
               acc_reg <= '0;
            end else if (acc_wr && ch_hit[gi]) begin
               acc_reg <= acc_res;
            end
         end

         assign acc_word[gi]                  = acc_reg;
         assign acc_out[gi*WIDTH +: WIDTH]    = acc_reg;
      end
   endgenerate

   // Hit vector instead of a range compare keeps non-power-of-two channel counts safe.
   assign ch_legal = |ch_hit;

   always_comb begin
      acc_cur = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (ch_hit[i]) acc_cur = acc_word[i];
      end
   end

   assign add_full = {1'b0, a_reg} + {1'b0, b_reg};
   assign sub_full = {1'b0, a_reg} - {1'b0, b_reg};
   assign acc_full = {1'b0, acc_cur} + {1'b0, a_reg};

   assign mul_addend  = lo_reg[0] ? a_reg : '0;
   assign mul_sum     = {1'b0, hi_reg} + {1'b0, mul_addend};
   assign mul_hi_next = mul_sum[WIDTH:1];
   assign mul_lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
   assign mul_ovf     = |mul_hi_next;
   assign mul_last    = (cnt_reg == CNTW'(WIDTH-1));

`ifdef WIRE_ALU_SAT_EN
   assign add_res = add_full[WIDTH] ? '1 : add_full[WIDTH-1:0];
   assign sub_res = sub_full[WIDTH] ? '0 : sub_full[WIDTH-1:0];
   assign acc_res = acc_full[WIDTH] ? '1 : acc_full[WIDTH-1:0];
   assign mul_res = mul_ovf         ? '1 : mul_lo_next;
`else
   assign add_res = add_full[WIDTH-1:0];
   assign sub_res = sub_full[WIDTH-1:0];
   assign acc_res = acc_full[WIDTH-1:0];
   assign mul_res = mul_lo_next;
`endif

   always_comb begin
      exec_res = add_res;
      exec_ovf = add_full[WIDTH];
      case (op_reg)
         OP_SUB: begin
            exec_res = sub_res;
            exec_ovf = sub_full[WIDTH];
         end
         OP_ACC: begin
            exec_res = acc_res;
            exec_ovf = acc_full[WIDTH];
         end
         default: ;
      endcase
   end

   always_ff @(posedge okClk or posedge reset) begin
      if (reset) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         op_reg     <= OP_ADD;
         ch_reg     <= '0;
         result_reg <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
         err_reg    <= 1'b0;
         hi_reg     <= '0;
         lo_reg     <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  a_reg     <= op_a;
                  b_reg     <= op_b;
                  op_reg    <= op_sel;
                  ch_reg    <= chan_sel;
                  busy_reg  <= 1'b1;
                  cnt_reg   <= '0;
                  hi_reg    <= '0;
                  lo_reg    <= op_b;
                  state_reg <= (op_sel == OP_MUL) ? S_MUL : S_EXEC;
               end
            end
            S_EXEC: begin
               busy_reg  <= 1'b0;
               done_reg  <= 1'b1;
               state_reg <= S_IDLE;
               if (op_reg == OP_ACC && !ch_legal) begin
                  ovf_reg <= 1'b0;
                  err_reg <= 1'b1;
               end else begin
                  result_reg <= exec_res;
                  ovf_reg    <= exec_ovf;
               end
            end
            S_MUL: begin
               hi_reg  <= mul_hi_next;
               lo_reg  <= mul_lo_next;
               cnt_reg <= cnt_reg + CNTW'(1);
               if (mul_last) begin
                  result_reg <= mul_res;
                  ovf_reg    <= mul_ovf;
                  busy_reg   <= 1'b0;
                  done_reg   <= 1'b1;
                  state_reg  <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign result = result_reg;
   assign busy   = busy_reg;
   assign done   = done_reg;
   assign ovf    = ovf_reg;
   assign err    = err_reg;

endmodule

// File: tb/tb_wire_alu.sv
// tb_wire_alu: directed-vector bench for wire_alu, a 4-channel instance plus a 3-channel
// instance for the illegal-channel case; expectations follow WIRE_ALU_SAT_EN when defined.
module tb_wire_alu;
   localparam int W = 32;

`ifdef WIRE_ALU_SAT_EN
   localparam logic [W-1:0] ADD_WRAP_EXP = 32'hFFFF_FFFF;
   localparam logic [W-1:0] SUB_EXP      = 32'h0000_0000;
   localparam logic [W-1:0] MULOV_EXP    = 32'hFFFF_FFFF;
   localparam logic [W-1:0] ADD7_EXP     = 32'hFFFF_FFFF;
`else
   localparam logic [W-1:0] ADD_WRAP_EXP = 32'h0000_0001;
   localparam logic [W-1:0] SUB_EXP      = 32'hFFFF_FFFE;
   localparam logic [W-1:0] MULOV_EXP    = 32'h0000_0000;
   localparam logic [W-1:0] ADD7_EXP     = 32'h0000_0006;
`endif

   logic           okClk = 1'b0;
   logic           reset, start, start3, acc_clr;
   logic [1:0]     op_sel, chan_sel;
   logic [W-1:0]   op_a, op_b;
   logic [W-1:0]   result, result3;
   logic [4*W-1:0] acc_out;
   logic [3*W-1:0] acc_out3;
   logic           busy, done, ovf, err;
   logic           busy3, done3, ovf3, err3;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 okClk = ~okClk;

   wire_alu #(.WIDTH(W), .CHANNELS(4)) u_dut (
      .okClk(okClk), .reset(reset), .start(start), .op_sel(op_sel), .chan_sel(chan_sel),
      .acc_clr(acc_clr), .op_a(op_a), .op_b(op_b), .result(result), .acc_out(acc_out),
      .busy(busy), .done(done), .ovf(ovf), .err(err)
   );

   wire_alu #(.WIDTH(W), .CHANNELS(3)) u_dut3 (
      .okClk(okClk), .reset(reset), .start(start3), .op_sel(op_sel), .chan_sel(chan_sel),
      .acc_clr(acc_clr), .op_a(op_a), .op_b(op_b), .result(result3), .acc_out(acc_out3),
      .busy(busy3), .done(done3), .ovf(ovf3), .err(err3)
   );

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge okClk);
      #1;
   endtask

   // Presents operands with a one-cycle start; returns 1 ns after the sampling edge k.
   task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] ch, input bit to3);
      op_sel   = op;
      op_a     = a;
      op_b     = b;
      chan_sel = ch;
      if (to3) start3 = 1'b1;
      else     start  = 1'b1;
      step();
      start  = 1'b0;
      start3 = 1'b0;
   endtask

   task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit intrude,
                          output int done_at, output int busy_cyc, output int dones,
                          output logic [W-1:0] res, output logic ov);
      launch(2'd3, a, b, 2'd0, 1'b0);
      done_at  = 0;
      dones    = 0;
      busy_cyc = busy ? 1 : 0;
      res      = 'x;
      ov       = 1'bx;
      for (int j = 1; j <= 40; j++) begin
         if (intrude && j == 5) begin
            op_sel = 2'd0; op_a = 32'd1; op_b = 32'd1; start = 1'b1;
         end
         if (intrude && j == 6) begin
            start = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h0000_0003;
         end
         step();
         if (busy) busy_cyc++;
         if (done) begin
            dones++;
            if (done_at == 0) begin
               done_at = j;
               res     = result;
               ov      = ovf;
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int             d_at, b_cyc, n_done;
      logic [W-1:0]   mres;
      logic           mov;

      reset = 1'b1; start = 1'b0; start3 = 1'b0; acc_clr = 1'b0;
      op_sel = '0; chan_sel = '0; op_a = '0; op_b = '0;
      repeat (2) @(posedge okClk);
      #1 reset = 1'b0;
      step();
      check_val("reset result", result, 0);
      check_val("reset acc_out", acc_out, 0);
      check_val("reset busy/done/ovf/err", {busy, done, ovf, err}, 4'b0000);

      // ADD wrap
      launch(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 2'd0, 1'b0);
      check_val("add busy at k", busy, 1);
      check_val("add done at k", done, 0);
      step();
      check_val("add result", result, ADD_WRAP_EXP);
      check_val("add ovf", ovf, 1);
      check_val("add done at k+1", done, 1);
      check_val("add busy at k+1", busy, 0);
      step();
      check_val("add done one cycle", done, 0);

      // SUB borrow
      launch(2'd1, 32'd5, 32'd7, 2'd0, 1'b0);
      step();
      check_val("sub result", result, SUB_EXP);
      check_val("sub ovf", ovf, 1);

      // ACC channel isolation
      for (int i = 0; i < 3; i++) begin
         launch(2'd2, 32'd10, 32'd0, 2'd2, 1'b0);
         step();
      end
      check_val("acc ch2 result", result, 30);
      check_val("acc ch2 ovf", ovf, 0);
      launch(2'd2, 32'd3, 32'd0, 2'd1, 1'b0);
      step();
      check_val("acc ch0", acc_out[0*W +: W], 0);
      check_val("acc ch1", acc_out[1*W +: W], 3);
      check_val("acc ch2", acc_out[2*W +: W], 30);
      check_val("acc ch3", acc_out[3*W +: W], 0);

      // Clear collides with ACC completion on ch2
      launch(2'd2, 32'd10, 32'd0, 2'd2, 1'b0);
      acc_clr = 1'b1;
      step();
      acc_clr = 1'b0;
      check_val("clr-win ch2", acc_out[2*W +: W], 0);
      check_val("clr-win result", result, 40);
      check_val("clr-win ch1 kept", acc_out[1*W +: W], 3);
      check_val("clr-win done", done, 1);

      // MUL latency and overflow
      run_mul(32'h0001_0000, 32'h0001_0000, 1'b0, d_at, b_cyc, n_done, mres, mov);
      check_val("mul ovf done_at", d_at, 32);
      check_val("mul ovf busy cycles", b_cyc, 32);
      check_val("mul ovf result", mres, MULOV_EXP);
      check_val("mul ovf flag", mov, 1);

      // MUL with a start issued mid-operation and operands changing underneath
      run_mul(32'd1234, 32'd5678, 1'b1, d_at, b_cyc, n_done, mres, mov);
      check_val("mul result", mres, 32'd7006652);
      check_val("mul ovf clear", mov, 0);
      check_val("mul single done", n_done, 1);
      check_val("mul done_at", d_at, 32);
      check_val("mul idle after", busy, 0);
      check_val("err stays 0", err, 0);

      // Reset in the middle of a MUL
      launch(2'd3, 32'd3, 32'd4, 2'd0, 1'b0);
      repeat (9) step();
      check_val("mul running before reset", busy, 1);
      reset = 1'b1;
      #1;
      check_val("async reset result", result, 0);
      check_val("async reset acc_out", acc_out, 0);
      check_val("async reset flags", {busy, done, ovf, err}, 4'b0000);
      step();
      reset = 1'b0;
      n_done = 0;
      for (int j = 0; j < 40; j++) begin
         step();
         if (done) n_done++;
      end
      check_val("no done after abort", n_done, 0);
      launch(2'd0, 32'd2, 32'd3, 2'd0, 1'b0);
      step();
      check_val("post-reset add result", result, 5);
      check_val("post-reset add done", done, 1);

      // Illegal channel on the 3-channel instance
      launch(2'd2, 32'd5, 32'd0, 2'd1, 1'b1);
      step();
      check_val("ch3dut acc ch1 result", result3, 5);
      launch(2'd0, 32'hFFFF_FFFF, 32'd7, 2'd0, 1'b1);
      step();
      check_val("ch3dut add result", result3, ADD7_EXP);
      check_val("ch3dut add ovf", ovf3, 1);
      check_val("ch3dut err before", err3, 0);
      launch(2'd2, 32'd9, 32'd0, 2'd3, 1'b1);
      check_val("illegal done at k", done3, 0);
      step();
      check_val("illegal done", done3, 1);
      check_val("illegal err", err3, 1);
      check_val("illegal result held", result3, ADD7_EXP);
      check_val("illegal ovf", ovf3, 0);
      check_val("illegal acc unchanged", acc_out3, {32'd0, 32'd5, 32'd0});
      chan_sel = 2'd3;
      acc_clr  = 1'b1;
      step();
      acc_clr  = 1'b0;
      repeat (3) step();
      check_val("illegal err sticky", err3, 1);
      check_val("illegal clr ignored", acc_out3, {32'd0, 32'd5, 32'd0});
      check_val("4ch err unaffected", err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
